// File: rtl/pa2_seq_src.sv
// -----------------------------------------------------------------------------
// pa2_seq_src
//
// Stimulus source for a pa2_fsm matcher. On an accepted start it streams `len`
// beats of a chosen pattern (latched num, its complement, or LFSR bits) on
// valid/seq. It counts how many beats equal num, then watches the matcher's
// hit output for a fixed window. Hit is expected high for the first exp_cnt
// window cycles and low afterwards. The verdict is reported on
// pass/err_code with a one-cycle done pulse.
//
// Handshake: valid/seq is a push-only stream with no ready. A beat is
// transferred on every rising edge where valid=1, and the downstream matcher
// must accept it. seq is forced to 0 whenever valid=0.
//
// Parameters
//   CHK_WIN   hit-check window length in cycles (>= 16)
//   SEED      LFSR reset value (nonzero)
//
// Ports
//   clock      single clock, rising edge
//   reset      asynchronous, active-low
//   start      begin a sequence (sampled only in IDLE)
//   len[3:0]   number of beats to send (0-15)
//   mode[1:0]  00 RAND, 01 MATCH, 10 NO_MATCH, 11 RAND
//   num[3:0]   target value presented to the matcher
//   hit        hit output of the matcher under drive
//   valid      beat valid
//   seq[3:0]   beat value
//   busy       high in SEND, CHECK and DONE
//   done       one-cycle completion pulse
//   pass       result of the last sequence, held until the next start
//   err_code   00 none, 01 spurious hit, 10 missing hit
//   exp_cnt    matching beats sent in the current/last sequence
//   state_dbg  current FSM state (0 IDLE, 1 SEND, 2 CHECK, 3 DONE)
// -----------------------------------------------------------------------------
module pa2_seq_src #(
   parameter int         CHK_WIN = 16,
   parameter logic [7:0] SEED    = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] len,
   input  logic [1:0] mode,
   input  logic [3:0] num,
   input  logic       hit,
   output logic       valid,
   output logic [3:0] seq,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [1:0] err_code,
   output logic [3:0] exp_cnt,
   output logic [1:0] state_dbg
);

   localparam int KW = $clog2(CHK_WIN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, state_nx;

   // Registered datapath state
   logic [3:0]    len_q, num_q, beat_cnt;
   logic [1:0]    mode_q;
   logic [KW-1:0] k_cnt;
   logic [7:0]    lfsr;
   logic          serr;           // spurious hit seen during SEND

   // Next values of registered signals
   logic [3:0]    len_d, num_d, beat_d, seq_d, exp_d;
   logic [1:0]    mode_d, err_d;
   logic [KW-1:0] k_d;
   logic [7:0]    lfsr_d;
   logic          serr_d, valid_d, busy_d, done_d, pass_d;

   // Combinational helpers
   logic [1:0] cur_mode;
   logic [3:0] cur_num, beat_val, beat_base, exp_base;
   logic [7:0] lfsr_step;
   logic       cur_rand, accept, issue_beat, more_beats;
   logic       hit_exp, chk_miss, chk_last;

   // In IDLE the first beat is built from the live inputs because it is
   // registered on the same edge that accepts start; later beats use the
   // latched copies.
   always_comb begin
      cur_mode = (state == IDLE) ? mode : mode_q;
      cur_num  = (state == IDLE) ? num  : num_q;
      cur_rand = (cur_mode == 2'b00) || (cur_mode == 2'b11);
      case (cur_mode)
         2'b01:   beat_val = cur_num;
         2'b10:   beat_val = ~cur_num;
         default: beat_val = lfsr[3:0];
      endcase
   end

   // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
   assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

   assign accept     = (state == IDLE) && start;
   assign more_beats = (beat_cnt != len_q);
   assign issue_beat = (accept && (len != 4'd0)) || ((state == SEND) && more_beats);

   // Window cycle k expects hit while k < exp_cnt (KW >= 4 since CHK_WIN >= 16)
   assign hit_exp  = ({1'b0, k_cnt} < {{(KW-3){1'b0}}, exp_cnt});
   assign chk_miss = (state == CHECK) && (hit != hit_exp);
   assign chk_last = (k_cnt == KW'(CHK_WIN - 1));

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = (len == 4'd0) ? DONE : SEND;
         // A spurious hit, even one in the last beat, skips the window
         SEND:  if (!more_beats) state_nx = (serr || hit) ? DONE : CHECK;
         CHECK: if (chk_miss || chk_last) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ----------------------------------------------------- output / datapath comb
   always_comb begin
      valid_d   = 1'b0;
      seq_d     = 4'd0;
      busy_d    = (state_nx != IDLE);
      done_d    = (state_nx == DONE);
      pass_d    = pass;
      err_d     = err_code;
      exp_d     = exp_cnt;
      lfsr_d    = lfsr;
      beat_d    = beat_cnt;
      serr_d    = serr;
      len_d     = len_q;
      mode_d    = mode_q;
      num_d     = num_q;
      beat_base = beat_cnt;
      exp_base  = exp_cnt;
      k_d       = '0;

      if (accept) begin
         len_d     = len;
         mode_d    = mode;
         num_d     = num;
         exp_d     = 4'd0;
         err_d     = 2'b00;
         pass_d    = 1'b1;
         serr_d    = 1'b0;
         beat_d    = 4'd0;
         beat_base = 4'd0;
         exp_base  = 4'd0;
      end

      if (issue_beat) begin
         valid_d = 1'b1;
         seq_d   = beat_val;
         beat_d  = beat_base + 4'd1;
         exp_d   = exp_base + {3'b000, (beat_val == cur_num)};
         if (cur_rand) lfsr_d = lfsr_step;
      end

      if ((state == SEND) && hit) begin
         serr_d = 1'b1;
         err_d  = 2'b01;
         pass_d = 1'b0;
      end

      // k is held at 0 outside CHECK, so entry into CHECK always starts at k=0
      if (state == CHECK) k_d = k_cnt + KW'(1);

      if (chk_miss) begin
         pass_d = 1'b0;
         err_d  = hit ? 2'b01 : 2'b10;
      end
   end

   // ---------------------------------------------------------- output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid    <= 1'b0;
         seq      <= 4'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_code <= 2'b00;
         exp_cnt  <= 4'd0;
         lfsr     <= SEED;
         len_q    <= 4'd0;
         mode_q   <= 2'b00;
         num_q    <= 4'd0;
         beat_cnt <= 4'd0;
         k_cnt    <= '0;
         serr     <= 1'b0;
      end else begin
         valid    <= valid_d;
         seq      <= seq_d;
         busy     <= busy_d;
         done     <= done_d;
         pass     <= pass_d;
         err_code <= err_d;
         exp_cnt  <= exp_d;
         lfsr     <= lfsr_d;
         len_q    <= len_d;
         mode_q   <= mode_d;
         num_q    <= num_d;
         beat_cnt <= beat_d;
         k_cnt    <= k_d;
         serr     <= serr_d;
      end
   end

   assign state_dbg = state;

endmodule
